// File: rtl/rv_cycle_sequencer.sv
// Instruction phase sequencer: steps T through the phases of each instruction, stretches
// phases on slow memory, and supports halt, debug single-step and bus-timeout error states.
module rv_cycle_sequencer #(
  parameter int T_WIDTH   = 3,
  parameter int T_MAX     = 7,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 T_rst,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 hlt_req,
  input  logic                 resume,
  input  logic                 step_en,
  input  logic                 step_go,
  output logic [T_WIDTH-1:0]   T,
  output logic                 phase_en,
  output logic                 instr_done,
  output logic                 stalled,
  output logic                 halted,
  output logic                 bus_err,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_RUN, S_WAIT, S_HALT, S_STEP, S_ERR} state_t;

  state_t               state_q, state_d;
  logic [T_WIDTH-1:0]   t_q, t_d;
  logic [WC_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 stalled_q, halted_q, bus_err_q;
  logic                 last_phase;
  logic                 timeout_hit;

  always_comb begin
    last_phase  = (t_q == T_WIDTH'(T_MAX)) || T_rst;
    timeout_hit = (wcnt_q == WC_W'(TIMEOUT - 1));

    // Only RUN and WAIT can advance; the parked states ignore the memory handshake.
    phase_en = 1'b0;
    case (state_q)
      S_RUN:   phase_en = !(mem_req && !mem_ready);
      S_WAIT:  phase_en = mem_ready;
      default: phase_en = 1'b0;
    endcase
    instr_done = phase_en && last_phase;

    state_d   = state_q;
    t_d       = t_q;
    wcnt_d    = wcnt_q;
    instret_d = instret_q;

    if (phase_en) begin
      wcnt_d = '0;
      if (instr_done) begin
        t_d       = '0;
        instret_d = instret_q + 1'b1;
        if (hlt_req)      state_d = S_HALT;
        else if (step_en) state_d = S_STEP;
        else              state_d = S_RUN;
      end else begin
        t_d     = t_q + 1'b1;
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
        S_WAIT: begin
          if (timeout_hit) begin
            state_d = S_ERR;
            t_d     = '0;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        S_HALT: begin
          if (resume) state_d = step_en ? S_STEP : S_RUN;
        end
        S_STEP: begin
          if (hlt_req)                 state_d = S_HALT;
          else if (!step_en || step_go) state_d = S_RUN;
        end
        S_ERR: begin
          if (resume) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      t_q       <= '0;
      wcnt_q    <= '0;
      instret_q <= '0;
      stalled_q <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      wcnt_q    <= wcnt_d;
      instret_q <= instret_d;
      stalled_q <= (state_d == S_WAIT);
      halted_q  <= (state_d == S_HALT);
      bus_err_q <= (state_d == S_ERR);
    end
  end

  assign T       = t_q;
  assign instret = instret_q;
  assign stalled = stalled_q;
  assign halted  = halted_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_rv_cycle_sequencer.sv
// Scenario bench for rv_cycle_sequencer: per-cycle expectations queued as stimulus is
// applied and compared against the DUT at the falling edge.
module tb_rv_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, T_rst, mem_req, mem_ready, hlt_req, resume, step_en, step_go;
  logic [2:0]  T;
  logic        phase_en, instr_done, stalled, halted, bus_err;
  logic [31:0] instret;

  logic        rst2, mreq2;
  logic [0:0]  T2;
  logic        pe2, id2, st2, ha2, be2;
  logic [1:0]  ir2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [6:0]  in;
    logic [39:0] e;
  } cyc_t;

  cyc_t        plan[$];
  logic [39:0] sbq[$];
  logic [7:0]  sbw[$];
  cyc_t        cur;
  logic [39:0] obs, expv;
  logic [7:0]  obsw, expw;

  localparam logic [6:0] I_TRST = 7'b1000000;
  localparam logic [6:0] I_MREQ = 7'b0100000;
  localparam logic [6:0] I_RDY  = 7'b0010000;
  localparam logic [6:0] I_HLT  = 7'b0001000;
  localparam logic [6:0] I_RES  = 7'b0000100;
  localparam logic [6:0] I_SEN  = 7'b0000010;
  localparam logic [6:0] I_GO   = 7'b0000001;

  rv_cycle_sequencer dut (
    .clk(clk), .rst(rst), .T_rst(T_rst), .mem_req(mem_req), .mem_ready(mem_ready),
    .hlt_req(hlt_req), .resume(resume), .step_en(step_en), .step_go(step_go),
    .T(T), .phase_en(phase_en), .instr_done(instr_done), .stalled(stalled),
    .halted(halted), .bus_err(bus_err), .instret(instret)
  );

  rv_cycle_sequencer #(.T_WIDTH(1), .T_MAX(1), .CNT_WIDTH(2), .TIMEOUT(1)) u_small (
    .clk(clk), .rst(rst2), .T_rst(1'b0), .mem_req(mreq2), .mem_ready(1'b0),
    .hlt_req(1'b0), .resume(1'b0), .step_en(1'b0), .step_go(1'b0),
    .T(T2), .phase_en(pe2), .instr_done(id2), .stalled(st2),
    .halted(ha2), .bus_err(be2), .instret(ir2)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] ex(int t, int pe, int id, int st, int ha, int be, int ir);
    return {t[2:0], pe[0], id[0], st[0], ha[0], be[0], ir[31:0]};
  endfunction

  function automatic logic [7:0] exw(int t, int pe, int id, int st, int ha, int be, int ir);
    return {t[0], pe[0], id[0], st[0], ha[0], be[0], ir[1:0]};
  endfunction

  task automatic add(input logic [6:0] in, input logic [39:0] e);
    cyc_t c;
    c.in = in;
    c.e  = e;
    plan.push_back(c);
  endtask

  task automatic set_in(input logic [6:0] in);
    {T_rst, mem_req, mem_ready, hlt_req, resume, step_en, step_go} = in;
  endtask

  task automatic test_reset();
    set_in(I_MREQ | I_HLT | I_RES | I_SEN | I_GO);
    for (int k = 0; k < 3; k++) begin
      sbq.push_back(ex(0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      expv = sbq.pop_front();
      obs  = {T, phase_en, instr_done, stalled, halted, bus_err, instret};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL reset cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
    set_in(7'b0);
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 16; i++) add(7'b0, ex(i % 8, 1, (i % 8 == 7), 0, 0, 0, i / 8));
    for (int k = 0; plan.size() > 0; k++) begin
      cur = plan.pop_front();
      set_in(cur.in);
      sbq.push_back(cur.e);
      @(negedge clk);
      expv = sbq.pop_front();
      obs  = {T, phase_en, instr_done, stalled, halted, bus_err, instret};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL free_run cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_t_rst();
    add(7'b0,   ex(0, 1, 0, 0, 0, 0, 2));
    add(7'b0,   ex(1, 1, 0, 0, 0, 0, 2));
    add(I_TRST, ex(2, 1, 1, 0, 0, 0, 2));
    add(7'b0,   ex(0, 1, 0, 0, 0, 0, 3));
    add(I_TRST, ex(1, 1, 1, 0, 0, 0, 3));
    for (int k = 0; plan.size() > 0; k++) begin
      cur = plan.pop_front();
      set_in(cur.in);
      sbq.push_back(cur.e);
      @(negedge clk);
      expv = sbq.pop_front();
      obs  = {T, phase_en, instr_done, stalled, halted, bus_err, instret};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL t_rst cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait();
    add(7'b0,           ex(0, 1, 0, 0, 0, 0, 4));
    add(I_MREQ,         ex(1, 0, 0, 0, 0, 0, 4));
    add(I_MREQ,         ex(1, 0, 0, 1, 0, 0, 4));
    add(I_MREQ,         ex(1, 0, 0, 1, 0, 0, 4));
    add(I_MREQ | I_RDY, ex(1, 1, 0, 1, 0, 0, 4));
    add(I_TRST,         ex(2, 1, 1, 0, 0, 0, 4));
    for (int k = 0; plan.size() > 0; k++) begin
      cur = plan.pop_front();
      set_in(cur.in);
      sbq.push_back(cur.e);
      @(negedge clk);
      expv = sbq.pop_front();
      obs  = {T, phase_en, instr_done, stalled, halted, bus_err, instret};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL wait cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    // Ready arriving on the last allowed wait cycle still completes the access.
    add(I_MREQ, ex(0, 0, 0, 0, 0, 0, 5));
    for (int i = 1; i < 16; i++) add(I_MREQ, ex(0, 0, 0, 1, 0, 0, 5));
    add(I_MREQ | I_RDY, ex(0, 1, 0, 1, 0, 0, 5));
    add(I_MREQ, ex(1, 0, 0, 0, 0, 0, 5));
    for (int i = 0; i < 16; i++) add(I_MREQ, ex(1, 0, 0, 1, 0, 0, 5));
    add(I_MREQ | I_RDY | I_TRST, ex(0, 0, 0, 0, 0, 1, 5));
    add(I_RES,  ex(0, 0, 0, 0, 0, 1, 5));
    add(I_TRST, ex(0, 1, 1, 0, 0, 0, 5));
    for (int k = 0; plan.size() > 0; k++) begin
      cur = plan.pop_front();
      set_in(cur.in);
      sbq.push_back(cur.e);
      @(negedge clk);
      expv = sbq.pop_front();
      obs  = {T, phase_en, instr_done, stalled, halted, bus_err, instret};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL timeout cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 3; i++) add(7'b0, ex(i, 1, 0, 0, 0, 0, 6));
    for (int i = 3; i < 7; i++) add(I_HLT, ex(i, 1, 0, 0, 0, 0, 6));
    add(I_HLT, ex(7, 1, 1, 0, 0, 0, 6));
    add(I_HLT | I_MREQ | I_RDY, ex(0, 0, 0, 0, 1, 0, 7));
    add(I_HLT,        ex(0, 0, 0, 0, 1, 0, 7));
    add(I_RES | I_GO, ex(0, 0, 0, 0, 1, 0, 7));
    add(7'b0,         ex(0, 1, 0, 0, 0, 0, 7));
    add(I_TRST,       ex(1, 1, 1, 0, 0, 0, 7));
    for (int k = 0; plan.size() > 0; k++) begin
      cur = plan.pop_front();
      set_in(cur.in);
      sbq.push_back(cur.e);
      @(negedge clk);
      expv = sbq.pop_front();
      obs  = {T, phase_en, instr_done, stalled, halted, bus_err, instret};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL halt cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_step();
    int ir;
    ir = 8;
    for (int i = 0; i < 8; i++) add(I_SEN, ex(i, 1, (i == 7), 0, 0, 0, ir));
    ir++;
    for (int p = 0; p < 3; p++) begin
      add(I_SEN | I_MREQ, ex(0, 0, 0, 0, 0, 0, ir));
      add(I_SEN | I_GO,   ex(0, 0, 0, 0, 0, 0, ir));
      for (int i = 0; i < 8; i++) add(I_SEN, ex(i, 1, (i == 7), 0, 0, 0, ir));
      ir++;
    end
    add(I_SEN | I_HLT | I_GO, ex(0, 0, 0, 0, 0, 0, ir));
    add(I_SEN | I_RES,        ex(0, 0, 0, 0, 1, 0, ir));
    add(7'b0,                 ex(0, 0, 0, 0, 0, 0, ir));
    for (int i = 0; i < 3; i++) add(7'b0, ex(i, 1, 0, 0, 0, 0, ir));
    for (int k = 0; plan.size() > 0; k++) begin
      cur = plan.pop_front();
      set_in(cur.in);
      sbq.push_back(cur.e);
      @(negedge clk);
      expv = sbq.pop_front();
      obs  = {T, phase_en, instr_done, stalled, halted, bus_err, instret};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL step cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", k, obs, expv);
      end
      @(posedge clk); #1;
    end
    // Asynchronous reset in the middle of an instruction, with no clock edge involved.
    rst = 1'b0;
    #1;
    n_chk++;
    if ({T, stalled, halted, bus_err, instret} !== {3'd0, 3'b000, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset got T=%0d st=%b ha=%b err=%b instret=%0d want all 0",
               T, stalled, halted, bus_err, instret);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mreq2 = 1'b0;
      sbw.push_back(exw(i % 2, 1, i % 2, 0, 0, 0, (i / 2) % 4));
      @(negedge clk);
      expw = sbw.pop_front();
      obsw = {T2, pe2, id2, st2, ha2, be2, ir2};
      n_chk++;
      if (obsw !== expw) begin
        n_fail++;
        $display("FAIL wrap cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h", i, obsw, expw);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      mreq2 = 1'b1;
      sbw.push_back(exw(0, 0, 0, (i == 1), 0, (i == 2), 1));
      @(negedge clk);
      expw = sbw.pop_front();
      obsw = {T2, pe2, id2, st2, ha2, be2, ir2};
      n_chk++;
      if (obsw !== expw) begin
        n_fail++;
        $display("FAIL short_timeout cyc%0d (T,pe,done,st,ha,err,instret) got %h want %h",
                 i, obsw, expw);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    rst2  = 1'b1;
    mreq2 = 1'b0;
    set_in(7'b0);
    #2;
    rst  = 1'b0;
    rst2 = 1'b0;
    test_reset();
    test_free_run();
    test_t_rst();
    test_wait();
    test_timeout();
    test_halt();
    test_step();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_cycle_sequencer.md
RV_CYCLE_SEQUENCER -- requirements
Module: rv_cycle_sequencer

Interface
REQ-001 SHALL have parameter T_WIDTH, default 3, meaning width of the phase counter T.
REQ-002 SHALL have parameter T_MAX, default 7, meaning the last phase index; legal range 1 .. 2^T_WIDTH-1.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning the width of the retired-instruction counter.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of wait cycles per memory access; legal range >= 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have port T_rst, input, 1 bit: the decoder ends the instruction early after the current phase.
REQ-008 SHALL have port mem_req, input, 1 bit: the current phase performs a memory access.
REQ-009 SHALL have port mem_ready, input, 1 bit: memory completes the access this cycle.
REQ-010 SHALL have port hlt_req, input, 1 bit: level request to halt at the next instruction boundary.
REQ-011 SHALL have port resume, input, 1 bit: single-cycle pulse to leave HALT or ERR.
REQ-012 SHALL have port step_en, input, 1 bit: level select for debug single-step mode.
REQ-013 SHALL have port step_go, input, 1 bit: single-cycle pulse to execute one instruction in STEP.
REQ-014 SHALL have port T, output, T_WIDTH bits: the current phase, registered.
REQ-015 SHALL have port phase_en, output, 1 bit: combinational; high when T advances at the next edge. It gates all datapath write enables.
REQ-016 SHALL have port instr_done, output, 1 bit: combinational; high in the last cycle of an instruction.
REQ-017 SHALL have port stalled, output, 1 bit: registered; high while the state is WAIT.
REQ-018 SHALL have port halted, output, 1 bit: registered; high while the state is HALT.
REQ-019 SHALL have port bus_err, output, 1 bit: registered; high while the state is ERR.
REQ-020 SHALL have port instret, output, CNT_WIDTH bits: count of retired instructions, registered.

Function
REQ-021 SHALL implement the states RUN, WAIT, HALT, STEP and ERR.
REQ-022 In RUN, phase_en SHALL be 1 unless (mem_req && !mem_ready); if (mem_req && !mem_ready), the next state SHALL be WAIT with T held.
REQ-023 In WAIT, T SHALL hold, and the wait counter SHALL increment each cycle that mem_ready=0.
REQ-024 In WAIT with mem_ready=1, phase_en SHALL be 1, the wait counter SHALL clear, and the advance SHALL proceed as in RUN.
REQ-025 In WAIT, when the wait counter reaches TIMEOUT-1 with mem_ready=0, the next state SHALL be ERR. In that same cycle mem_ready=1 takes priority.
REQ-026 On advance, if T==T_MAX or T_rst=1, then instr_done SHALL be 1, T SHALL become 0, and instret SHALL increment; otherwise T SHALL become T+1.
REQ-027 instret SHALL wrap modulo 2^CNT_WIDTH.
REQ-028 At instr_done, the next state SHALL be HALT if hlt_req=1, else STEP if step_en=1, else RUN.
REQ-029 hlt_req asserted mid-instruction SHALL take no effect until instr_done.
REQ-030 In HALT and STEP, T SHALL be 0 and phase_en SHALL be 0.
REQ-031 In HALT with resume=1, the next state SHALL be STEP if step_en=1, else RUN.
REQ-032 In HALT with resume and step_go both 1, resume SHALL govern.
REQ-033 In STEP with step_go=1, the next state SHALL be RUN; REQ-028 then returns the sequencer to STEP after exactly one instruction.
REQ-034 In STEP with step_en=0, the next state SHALL be RUN.
REQ-035 In STEP with hlt_req=1, the next state SHALL be HALT, with priority over step_go.
REQ-036 In ERR, T SHALL be 0 and phase_en SHALL be 0; resume SHALL clear ERR to RUN; instret SHALL not increment.
REQ-037 In HALT, STEP and ERR, mem_req and mem_ready SHALL be ignored.
REQ-038 instr_done SHALL never be asserted outside RUN or WAIT.

Reset
REQ-039 While rst=0, the sequencer SHALL be in state RUN with T=0, instret=0, wait counter=0, and stalled=halted=bus_err=0, regardless of clk.
REQ-040 Reset asserted mid-WAIT or mid-instruction SHALL abort it without incrementing instret.
REQ-041 The first advance after reset SHALL occur at the first rising edge with rst=1.

Verification
REQ-042 Free run, defaults, all inputs 0, for 16 cycles -> T follows 0..7,0..7; instr_done high when T=7; instret=2.
REQ-043 T_rst=1 at T=2 -> T goes 0,1,2,0; instret +1.
REQ-044 mem_req=1 at T=1 with mem_ready held low 3 cycles -> stalled=1 for 3 cycles; T stays 1; advance to T=2 on the ready cycle.
REQ-045 mem_req=1, mem_ready=0 for 16 cycles with TIMEOUT=16 -> bus_err=1 and T=0; resume -> RUN with bus_err=0.
REQ-046 hlt_req=1 raised at T=3 -> halted=1 after T=7 completes; resume -> RUN.
REQ-047 step_en=1 with three step_go pulses -> instret=+3, STEP with T=0 between pulses; rst=0 mid-instruction -> T=0, instret=0.
